// File: rtl/replace_num_sub.sv
// Replacement-number reader: numbers accepted samples, does a clear-on-read lookup
// and forwards either the stored replacement or the original. Option: REPLACE_NUM_SUB_STATS_EN.
module replace_num_sub #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  n_reset_i,
    input  logic                  run_i,
    input  logic                  restart_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    output logic                  mem_rd_en_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_valid_i
`ifdef REPLACE_NUM_SUB_STATS_EN
    ,
    output logic [15:0]           replaced_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr_q;
    logic                    mem_rd_en_q;
    logic [ADDR_WIDTH-1:0]   seq_ctr_q;
    logic [ADDR_WIDTH-1:0]   seq_ctr_d;
    logic                    substitute;

    // Only meaningful in WAIT, when the memory is presenting the looked-up word.
    assign substitute = run_i && mem_valid_i;

    always_comb begin
        seq_ctr_d = seq_ctr_q;
        if (!run_i || restart_i) begin
            seq_ctr_d = '0;
        end else if (state_q == ST_WAIT) begin
            seq_ctr_d = seq_ctr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            sample_q      <= '0;
            mem_rd_addr_q <= '0;
            mem_rd_en_q   <= 1'b0;
            seq_ctr_q     <= '0;
        end else begin
            seq_ctr_q <= seq_ctr_d;
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        sample_q      <= in_data_i;
                        mem_rd_addr_q <= seq_ctr_q;
                        mem_rd_en_q   <= run_i;
                        in_ready_q    <= 1'b0;
                        state_q       <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    out_data_q  <= substitute ? mem_data_i : sample_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign mem_rd_addr_o = mem_rd_addr_q;
    assign mem_rd_en_o   = mem_rd_en_q;

`ifdef REPLACE_NUM_SUB_STATS_EN
    logic [15:0] replaced_count_q;
    logic [15:0] replaced_count_d;

    always_comb begin
        replaced_count_d = replaced_count_q;
        if (restart_i) begin
            replaced_count_d = '0;
        end else if ((state_q == ST_WAIT) && substitute && (replaced_count_q != 16'hFFFF)) begin
            replaced_count_d = replaced_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            replaced_count_q <= '0;
        end else begin
            replaced_count_q <= replaced_count_d;
        end
    end

    assign replaced_count_o = replaced_count_q;
`endif

endmodule

// File: tb/tb_replace_num_sub.sv
// Randomised self-checking bench for replace_num_sub (ADDR_WIDTH=2 so wrap is exercised often).
module tb_replace_num_sub;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          run = 1'b0;
    logic          restart = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_data = '0;
    logic          mem_valid = 1'b0;
`ifdef REPLACE_NUM_SUB_STATS_EN
    logic [15:0]   replaced_count;
`endif

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    always #5 clk = ~clk;

    replace_num_sub #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i         (clk),
        .n_reset_i     (n_reset),
        .run_i         (run),
        .restart_i     (restart),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_en_o   (mem_rd_en),
        .mem_data_i    (mem_data),
        .mem_valid_i   (mem_valid)
`ifdef REPLACE_NUM_SUB_STATS_EN
        ,
        .replaced_count_o (replaced_count)
`endif
    );

    // Environment memory: registered read, clear-on-read of the valid flag.
    logic [DW-1:0] env_dat [DEPTH];
    logic          env_vld [DEPTH];
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_vld = 1'b0;

    always @(posedge clk) begin
        if (wr_en) begin
            env_dat[wr_addr] <= wr_data;
            env_vld[wr_addr] <= wr_vld;
        end
        if (mem_rd_en) begin
            mem_data <= env_dat[mem_rd_addr];
            mem_valid <= env_vld[mem_rd_addr];
            env_vld[mem_rd_addr] <= 1'b0;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_dat [DEPTH];
    bit            ref_vld [DEPTH];
    int            ref_ctr = 0;
    int            ref_repl = 0;

    task automatic mem_write(input int a, input logic [DW-1:0] d, input bit v);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_vld = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
        ref_dat[a] = d;
        ref_vld[a] = v;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < DEPTH; a++) mem_write(a, 8'h00, 1'b0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        ref_ctr = 0;
        ref_repl = 0;
    endtask

    // Expected result of one sample from the substitution rules.
    task automatic ref_predict(input logic [DW-1:0] d, input bit run_a, input bit run_w,
                               output logic [DW-1:0] exp_data, output int exp_addr,
                               output int exp_pulses);
        bit            hit;
        logic [DW-1:0] v;
        hit = 1'b0;
        v = '0;
        if (!run_a) ref_ctr = 0;
        exp_pulses = run_a ? 1 : 0;
        exp_addr = run_a ? ref_ctr : -1;
        if (run_a) begin
            hit = ref_vld[ref_ctr];
            v = ref_dat[ref_ctr];
            ref_vld[ref_ctr] = 1'b0;
        end
        exp_data = (run_w && hit) ? v : d;
        if (run_w && hit && ref_repl < 65535) ref_repl++;
        if (run_a && run_w) ref_ctr = (ref_ctr + 1) % DEPTH;
        if (!run_w) ref_ctr = 0;
    endtask

    // Drives one sample through the block and reports what was observed.
    task automatic do_sample(input logic [DW-1:0] d, input bit run_a, input bit run_w,
                             input int stall, output logic [DW-1:0] got, output int got_addr,
                             output int pulses, output int lat, output bit hold_ok,
                             output bit to);
        bit acc;
        got = '0; got_addr = -1; pulses = 0; lat = -1; hold_ok = 1'b1; to = 1'b0; acc = 1'b0;
        run = run_a; in_data = d; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
        end
        if (!acc) begin
            in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        run = run_w;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_rd_en) begin
                pulses++;
                got_addr = int'(mem_rd_addr);
            end
            if (out_valid) begin
                lat = i - 1;
                break;
            end
        end
        if (lat < 0) begin
            to = 1'b1;
            return;
        end
        got = out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (out_data !== got || out_valid !== 1'b1 || in_ready !== 1'b0 || mem_rd_en !== 1'b0)
                hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid !== 1'b0) hold_ok = 1'b0;
        txn_no++;
        $display("txn %0d: in=%h run=%0d/%0d out=%h addr=%0d pulses=%0d lat=%0d",
                 txn_no, d, run_a, run_w, got, got_addr, pulses, lat);
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        #23;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || mem_rd_en !== 1'b0 ||
            mem_rd_addr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b ir=%b re=%b ra=%h od=%h required all zero",
                     out_valid, in_ready, mem_rd_en, mem_rd_addr, out_data);
        end
        clear_mem();
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b required 1", in_ready);
        end
`ifdef REPLACE_NUM_SUB_STATS_EN
        checks++;
        if (replaced_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", replaced_count);
        end
`endif
        ref_ctr = 0;
        ref_repl = 0;
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] tbl [3];
        logic [DW-1:0] got, exp_d;
        int ga, pl, lat, ea, ep;
        bit hold, to;
        tbl = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            ref_predict(tbl[i], 1'b0, 1'b0, exp_d, ea, ep);
            do_sample(tbl[i], 1'b0, 1'b0, 0, got, ga, pl, lat, hold, to);
            checks++;
            if (to || got !== exp_d || pl !== ep || lat !== 2) begin
                errors++;
                $display("FAIL passthrough_%0d: got data=%h pulses=%0d lat=%0d to=%0d required data=%h pulses=%0d lat=2",
                         i, got, pl, lat, to, exp_d, ep);
            end
        end
    endtask

    task automatic test_addr_seq();
        logic [DW-1:0] tbl [3];
        logic [DW-1:0] got, exp_d;
        int ga, pl, lat, ea, ep;
        bit hold, to;
        tbl = '{8'h5C, 8'hC3, 8'h07};
        do_restart();
        clear_mem();
        for (int i = 0; i < 3; i++) begin
            ref_predict(tbl[i], 1'b1, 1'b1, exp_d, ea, ep);
            do_sample(tbl[i], 1'b1, 1'b1, 0, got, ga, pl, lat, hold, to);
            checks++;
            if (to || ga !== ea || pl !== 1 || got !== exp_d) begin
                errors++;
                $display("FAIL addr_seq_%0d: got addr=%0d pulses=%0d data=%h required addr=%0d pulses=1 data=%h",
                         i, ga, pl, got, ea, exp_d);
            end
        end
    endtask

    task automatic test_substitute();
        logic [DW-1:0] tbl [3];
        logic [DW-1:0] got, exp_d;
        int ga, pl, lat, ea, ep;
        bit hold, to;
        tbl = '{8'h10, 8'h20, 8'h30};
        do_restart();
        clear_mem();
        mem_write(1, 8'hAB, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ref_predict(tbl[i], 1'b1, 1'b1, exp_d, ea, ep);
            do_sample(tbl[i], 1'b1, 1'b1, 0, got, ga, pl, lat, hold, to);
            checks++;
            if (to || got !== exp_d || ga !== ea || lat !== 2) begin
                errors++;
                $display("FAIL substitute_%0d: got data=%h addr=%0d lat=%0d required data=%h addr=%0d lat=2",
                         i, got, ga, lat, exp_d, ea);
            end
        end
`ifdef REPLACE_NUM_SUB_STATS_EN
        checks++;
        if (replaced_count !== 16'(ref_repl)) begin
            errors++;
            $display("FAIL substitute_count: got %0d required %0d", replaced_count, ref_repl);
        end
`endif
    endtask

    task automatic test_wrap_restart();
        logic [DW-1:0] got, exp_d;
        int ga, pl, lat, ea, ep;
        bit hold, to;
        do_restart();
        for (int i = 0; i < 8; i++) begin
            if (i == 5 || i == 7) do_restart();
            ref_predict(8'(i * 13), 1'b1, 1'b1, exp_d, ea, ep);
            do_sample(8'(i * 13), 1'b1, 1'b1, 0, got, ga, pl, lat, hold, to);
            checks++;
            if (to || ga !== ea || got !== exp_d) begin
                errors++;
                $display("FAIL wrap_restart_%0d: got addr=%0d data=%h required addr=%0d data=%h",
                         i, ga, got, ea, exp_d);
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] got, exp_d;
        int ga, pl, lat, ea, ep;
        bit hold, to;
        mem_write(ref_ctr, 8'hE7, 1'b1);
        ref_predict(8'h42, 1'b1, 1'b1, exp_d, ea, ep);
        do_sample(8'h42, 1'b1, 1'b1, 10, got, ga, pl, lat, hold, to);
        checks++;
        if (to || !hold || got !== exp_d || pl !== 1) begin
            errors++;
            $display("FAIL stall_hold: got data=%h hold_ok=%0d pulses=%0d to=%0d required data=%h hold_ok=1 pulses=1",
                     got, hold, pl, to, exp_d);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d, got, exp_d;
        int ga, pl, lat, ea, ep, r;
        bit hold, to, ra, rw;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                mem_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            r = int'($urandom_range(0, 9));
            ra = (r >= 2);
            rw = (r >= 3);
            d = 8'($urandom);
            ref_predict(d, ra, rw, exp_d, ea, ep);
            do_sample(d, ra, rw, int'($urandom_range(0, 3)), got, ga, pl, lat, hold, to);
            checks++;
            if (to || !hold || got !== exp_d || pl !== ep || (ep == 1 && ga !== ea) || lat !== 2) begin
                errors++;
                $display("FAIL random_%0d: got data=%h addr=%0d pulses=%0d lat=%0d hold=%0d required data=%h addr=%0d pulses=%0d lat=2",
                         i, got, ga, pl, lat, hold, exp_d, ea, ep);
            end
        end
`ifdef REPLACE_NUM_SUB_STATS_EN
        checks++;
        if (replaced_count !== 16'(ref_repl)) begin
            errors++;
            $display("FAIL random_count: got %0d required %0d", replaced_count, ref_repl);
        end
`endif
    endtask

    task automatic test_reset_lookup();
        logic [DW-1:0] got, exp_d;
        int ga, pl, lat, ea, ep;
        bit hold, to, acc;
        acc = 1'b0;
        if (ref_ctr == 0) begin
            ref_predict(8'h01, 1'b1, 1'b1, exp_d, ea, ep);
            do_sample(8'h01, 1'b1, 1'b1, 0, got, ga, pl, lat, hold, to);
        end
        mem_write(0, 8'h9D, 1'b1);
        run = 1'b1; in_data = 8'h5A; in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (!acc || mem_rd_en !== 1'b1 || int'(mem_rd_addr) !== ref_ctr) begin
            errors++;
            $display("FAIL lookup_issue: got en=%b addr=%0d required en=1 addr=%0d", mem_rd_en, mem_rd_addr, ref_ctr);
        end
        n_reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mem_rd_en !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_lookup: got ov=%b re=%b ir=%b required 0 0 0", out_valid, mem_rd_en, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        ref_ctr = 0;
        ref_repl = 0;
        ref_predict(8'h66, 1'b1, 1'b1, exp_d, ea, ep);
        do_sample(8'h66, 1'b1, 1'b1, 0, got, ga, pl, lat, hold, to);
        checks++;
        if (to || ga !== 0 || got !== exp_d) begin
            errors++;
            $display("FAIL after_reset_addr: got addr=%0d data=%h required addr=0 data=%h", ga, got, exp_d);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_addr_seq();
        test_substitute();
        test_wrap_restart();
        test_stall();
        test_random();
        test_reset_lookup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
